ps2_uart_rx_conditioner: RTL and testbench
==========================================

# ps2_uart_rx_conditioner

Parametrised receive-side conditioner between Playstation 2 low-voltage UART lines and the FT2232 AD bus. It replaces the plain pin-to-pin RX feed. Each of `CHANNELS` target RX lines is:
- synchronised into the CPLD clock domain;
- deglitched by a stability filter;
- checked for a UART break condition.

It also drives a shared, stretched activity indicator. Data flow stays PS2 → host only; the block never drives the target.

## Interface
Parameters:
- `CHANNELS`, 1 — number of independent RX lines.
- `SYNC_STAGES`, 2 — synchroniser flops per line, minimum 2.
- `FILTER_LEN`, 4 — consecutive identical samples required to change filtered level, minimum 1 (1 = no filtering).
- `BREAK_CYCLES`, 4096 — consecutive filtered-low cycles that declare a break, minimum 2.
- `LED_CYCLES`, 1048576 — activity stretch length in clocks, minimum 1.

Ports:
- `CLK` in 1 — single system clock.
- `nRST` in 1 — asynchronous, active-low reset. Release is assumed synchronous to `CLK` externally.
- `rx_in` in `CHANNELS` — raw target RX pins (e.g. `nTRST` on channel 0). Asynchronous; idle high.
- `enable` in 1 — synchronous to `CLK`. When 0, all `rx_out` bits are held at idle (1).
- `rx_out` out `CHANNELS` — conditioned RX to the FT AD bus (e.g. `FT_AD1_TDI`). Registered.
- `brk` out `CHANNELS` — high while the channel is in break. Registered.
- `led_act` out 1 — high while activity stretch is running. Registered.

## Operation
- Reset (`nRST`=0, asynchronous) forces:
  - all synchroniser flops and filter levels to 1;
  - filter counters and break counters to 0;
  - `rx_out` to all 1, `brk` to all 0, `led_act` to 0, LED counter to 0.
- Synchroniser: `SYNC_STAGES` flops per bit. `s` denotes the final-stage output.
- Filter, per channel: level register `f` and counter `c`, width `$clog2(FILTER_LEN+1)`.
  - If `s == f`: `c` ← 0.
  - If `s != f` and `c == FILTER_LEN-1`: `f` ← `s` and `c` ← 0.
  - Otherwise: `c` ← `c+1`.
  - A pulse shorter than `FILTER_LEN` samples never reaches `f`.
  - `c` never exceeds `FILTER_LEN-1`.
- Output: `rx_out[i]` ← `enable ? f_next[i] : 1`, registered in the same edge as `f`. There is no extra pipeline stage.
- Break, per channel: counter `b`, width `$clog2(BREAK_CYCLES+1)`.
  - While `f == 0`, `b` increments and saturates at `BREAK_CYCLES`.
  - When `f == 1`, `b` ← 0.
  - `brk[i]` ← (`b_next == BREAK_CYCLES`).
  - Break detection is independent of `enable`.
- Activity:
  - A filtered falling edge is `f` 1→0. On any channel, it loads the LED counter with `LED_CYCLES`.
  - Otherwise a nonzero counter decrements.
  - `led_act` ← (`counter_next != 0`).
  - Simultaneous edges on several channels count as one load.
  - An edge while the counter is running reloads it (retrigger).
- Channels are fully independent apart from the shared LED counter.

## Timing
- Input-to-output latency: an `rx_in` transition sampled at edge 1 appears on `rx_out` at edge `SYNC_STAGES + FILTER_LEN`. With defaults this is edge 6.
- `enable` 1→0: `rx_out` = 1 after the next edge. `enable` 0→1: `rx_out` shows current `f` after the next edge.
- `brk` asserts on the `BREAK_CYCLES`-th edge with `f == 0`. It deasserts on the edge where `f` returns to 1.
- `led_act` asserts on the same edge `rx_out` first goes low. It stays high `LED_CYCLES` edges after the last filtered falling edge.
- Reset mid-frame or mid-break:
  - all outputs immediately go to their reset values;
  - after release, a line still low needs the full filter latency plus `BREAK_CYCLES` before `brk` re-asserts.

## Structure
- Shared package `ps2_uart_pkg`:
  - default parameter constants;
  - the idle-level constant (`1'b1`);
  - a width helper for counters.
- Sub-module `ps2_uart_rx_chan`: synchroniser, filter and break counter for one line. It is instantiated `CHANNELS` times through a generate loop.
- The top level holds the enable gating, the falling-edge OR reduction and the LED counter.

## Test plan
All scenarios use defaults (`SYNC_STAGES`=2, `FILTER_LEN`=4) unless stated.
- Reset: assert `nRST` with `rx_in`=0 → `rx_out`=1, `brk`=0, `led_act`=0, held throughout reset.
- Glitch reject: 3-cycle low pulse on `rx_in[0]` → `rx_out[0]` stays 1 and `led_act` stays 0. A 4-cycle low pulse → `rx_out[0]` is low on edges 6–9 and `led_act` rises at edge 6.
- Byte pass-through: 0x55 at 8N1, 16 clocks/bit → `rx_out` reproduces the waveform delayed by exactly 6 clocks with identical bit widths.
- Break: `BREAK_CYCLES`=16, hold `rx_in` low 30 cycles then high → `brk` high from edge 21 until edge 36 (6 edges after release), then 0.
- Enable/LED: `enable`=0 during a frame → `rx_out`=1, while `brk` and `led_act` still respond. Second falling edge 5 cycles into the stretch (`LED_CYCLES`=10) → `led_act` stays high 10 cycles after the second edge.
- Multichannel: `CHANNELS`=2, simultaneous falling edges → both `rx_out` bits fall together and only one LED load occurs. Glitch on channel 1 → channel 0 is unaffected.

Source files
------------

// File: rtl/ps2_uart_rx_conditioner_pkg.sv
// Shared constants and helpers for the PS2 UART receive conditioner.
package ps2_uart_pkg;

  // Default parameter values for the conditioner and its per-line channel.
  localparam int DEF_CHANNELS     = 1;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_FILTER_LEN   = 4;
  localparam int DEF_BREAK_CYCLES = 4096;
  localparam int DEF_LED_CYCLES   = 1048576;

  // A UART line idles (marks) high; this is also the safe level toward the host.
  localparam logic IDLE_LVL = 1'b1;

  // Width of a counter that must be able to hold the value max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ps2_uart_rx_conditioner_if.sv
// RX-side bus between the target pins / host AD bus and the conditioner.
interface ps2_uart_rx_conditioner_if #(
  parameter int CHANNELS = 1
);

  logic [CHANNELS-1:0] rx_in;    // raw target RX pins, asynchronous, idle high
  logic                enable;   // synchronous output enable toward the host
  logic [CHANNELS-1:0] rx_out;   // conditioned RX toward the FT AD bus
  logic [CHANNELS-1:0] brk;      // per-channel break indication
  logic                led_act;  // stretched activity indicator

  // Side that owns the pins and the enable (board / testbench).
  modport master (
    output rx_in, enable,
    input  rx_out, brk, led_act
  );

  // The conditioner itself.
  modport slave (
    input  rx_in, enable,
    output rx_out, brk, led_act
  );

endinterface

// File: rtl/ps2_uart_rx_conditioner_chan.sv
// One RX line: synchroniser, stability filter and break counter.
// f_next is exported so the top can register rx_out on the same edge as f.
module ps2_uart_rx_chan
  import ps2_uart_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int FILTER_LEN   = DEF_FILTER_LEN,
  parameter int BREAK_CYCLES = DEF_BREAK_CYCLES
) (
  input  logic CLK,
  input  logic nRST,
  input  logic rx_raw,
  output logic f,
  output logic f_next,
  output logic brk
);

  localparam int CW = cnt_w(FILTER_LEN);
  localparam int BW = cnt_w(BREAK_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CW-1:0]          c, c_next;
  logic [BW-1:0]          b, b_next;

  // Synchroniser chain; resets to idle so a reset never fakes a start bit.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) sync <= {SYNC_STAGES{IDLE_LVL}};
    else       sync <= {sync[SYNC_STAGES-2:0], rx_raw};
  end

  assign s = sync[SYNC_STAGES-1];

  // Filter and break next-state: the level only moves after FILTER_LEN
  // consecutive disagreeing samples; break counts cycles of filtered low,
  // judged on f_next so brk lines up with the edge rx_out changes on.
  always_comb begin
    f_next = f;
    c_next = '0;
    if (s != f) begin
      if (c == CW'(FILTER_LEN - 1)) f_next = s;
      else                          c_next = c + CW'(1);
    end
    if (f_next == 1'b0) b_next = (b == BW'(BREAK_CYCLES)) ? b : b + BW'(1);
    else                b_next = '0;
  end

  // Filter level, filter counter, break counter and registered break flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      f   <= IDLE_LVL;
      c   <= '0;
      b   <= '0;
      brk <= 1'b0;
    end else begin
      f   <= f_next;
      c   <= c_next;
      b   <= b_next;
      brk <= (b_next == BW'(BREAK_CYCLES));
    end
  end

endmodule

// File: rtl/ps2_uart_rx_conditioner.sv
// Receive-side conditioner between PS2 UART lines and the FT2232 AD bus.
// Per-line conditioning lives in ps2_uart_rx_chan; this level adds the
// host-side enable gating and the shared, retriggerable activity stretch.
module ps2_uart_rx_conditioner
  import ps2_uart_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int FILTER_LEN   = DEF_FILTER_LEN,
  parameter int BREAK_CYCLES = DEF_BREAK_CYCLES,
  parameter int LED_CYCLES   = DEF_LED_CYCLES
) (
  input logic                       CLK,
  input logic                       nRST,
  ps2_uart_rx_conditioner_if.slave  bus
);

  localparam int LW = cnt_w(LED_CYCLES);

  logic [CHANNELS-1:0] f, f_next, brk_ch;
  logic                fall;
  logic [LW-1:0]       led_cnt, led_next;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    ps2_uart_rx_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_LEN   (FILTER_LEN),
      .BREAK_CYCLES (BREAK_CYCLES)
    ) u_chan (
      .CLK    (CLK),
      .nRST   (nRST),
      .rx_raw (bus.rx_in[i]),
      .f      (f[i]),
      .f_next (f_next[i]),
      .brk    (brk_ch[i])
    );
  end

  assign bus.brk = brk_ch;

  // Any filtered 1->0 on any line is one activity event, however many coincide.
  assign fall = |(f & ~f_next);

  // Activity stretch: load on an edge (also while running), else count down.
  always_comb begin
    led_next = '0;
    if (fall)                 led_next = LW'(LED_CYCLES);
    else if (led_cnt != '0)   led_next = led_cnt - LW'(1);
  end

  // Output registers: gated RX toward the host and the LED stretch.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bus.rx_out  <= {CHANNELS{IDLE_LVL}};
      led_cnt     <= '0;
      bus.led_act <= 1'b0;
    end else begin
      bus.rx_out  <= bus.enable ? f_next : {CHANNELS{IDLE_LVL}};
      led_cnt     <= led_next;
      bus.led_act <= (led_next != '0);
    end
  end

endmodule

// File: tb/tb_ps2_uart_rx_conditioner.sv
// Bench for ps2_uart_rx_conditioner: directed scenarios push hand-computed
// output-change events {cycle, rx_out, brk, led_act}; a monitor compares each
// observed change of the outputs against the head of the queue.
module tb_ps2_uart_rx_conditioner;

  localparam int CH = 2;
  localparam logic [4:0] IDLE = 5'b11000;  // {rx_out[1:0], brk[1:0], led_act}

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  ps2_uart_rx_conditioner_if #(.CHANNELS(CH)) bus ();

  ps2_uart_rx_conditioner #(
    .CHANNELS     (CH),
    .SYNC_STAGES  (2),
    .FILTER_LEN   (4),
    .BREAK_CYCLES (16),
    .LED_CYCLES   (10)
  ) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  typedef struct {
    int         cyc;
    logic [4:0] val;
    int         tag;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         base = 0;
  int         tag = 0;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [4:0] prev = IDLE;
  logic [9:0] frame;
  wire  [4:0] obs = {bus.rx_out, bus.brk, bus.led_act};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output change must match the next expected event.
  always @(negedge clk) begin
    if (mon_en && obs !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: cycle %0d outputs %b (was %b), required no change",
                 cyc, obs, prev);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.val !== obs) begin
          errors++;
          $display("FAIL event_tag%0d: cycle %0d outputs %b, required cycle %0d outputs %b",
                   mon_e.tag, cyc, obs, mon_e.cyc, mon_e.val);
        end
      end
      prev = obs;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Time origin of a scenario: inputs set now are sampled at edge 1.
  task automatic start(input int t);
    @(posedge clk);
    #2;
    base = cyc;
    tag  = t;
  endtask

  task automatic ev(input int k, input logic [4:0] v);
    exp_t e;
    e.cyc = base + k;
    e.val = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    step(25);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_tag%0d: %0d expected events not seen, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_now(input string n, input logic [4:0] req);
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL %s: outputs %b, required %b", n, obs, req);
    end
  endtask

  initial begin
    bus.rx_in  = 2'b00;
    bus.enable = 1'b1;
    nrst       = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_now("reset_hold", IDLE);
    end
    bus.rx_in = 2'b11;
    @(posedge clk);
    #2 nrst = 1'b1;
    mon_en = 1'b1;
    step(5);

    // 1: 3-cycle glitches on each channel are filtered out entirely
    start(1);
    bus.rx_in[0] = 1'b0; step(3); bus.rx_in[0] = 1'b1; step(6);
    bus.rx_in[1] = 1'b0; step(3); bus.rx_in[1] = 1'b1;
    settle();

    // 2: 4-cycle pulse on ch0 passes (edges 6..9) while a ch1 glitch does not
    start(2);
    ev(6, 5'b10001); ev(10, 5'b11001); ev(16, 5'b11000);
    bus.rx_in = 2'b00; step(3); bus.rx_in[1] = 1'b1; step(1); bus.rx_in[0] = 1'b1;
    settle();

    // 3: 0x55 8N1 at 16 clk/bit on ch0; each 16-clock low is exactly a break
    start(3);
    for (int j = 0; j < 5; j++) begin
      ev(6 + 32 * j,      5'b10001);
      ev(6 + 32 * j + 10, 5'b10000);
      ev(6 + 32 * j + 15, 5'b10010);
      ev(6 + 32 * j + 16, 5'b11000);
    end
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx_in[0] = frame[i];
      step(16);
    end
    settle();

    // 4: 30-cycle low: brk from edge 21 until edge 36
    start(4);
    ev(6, 5'b10001); ev(16, 5'b10000); ev(21, 5'b10010); ev(36, 5'b11000);
    bus.rx_in[0] = 1'b0; step(30); bus.rx_in[0] = 1'b1;
    settle();

    // 5: enable low for a whole frame: rx_out idle, brk and led still move
    start(5);
    ev(6, 5'b11001); ev(16, 5'b11000); ev(21, 5'b11010); ev(26, 5'b11000);
    bus.enable = 1'b0; bus.rx_in[0] = 1'b0; step(20);
    bus.rx_in[0] = 1'b1; step(10); bus.enable = 1'b1;
    settle();

    // 6: enable dropped and restored while the filtered line is low
    start(6);
    ev(6, 5'b10001); ev(11, 5'b11001); ev(15, 5'b10001);
    ev(16, 5'b10000); ev(21, 5'b10010); ev(24, 5'b11000);
    bus.rx_in[0] = 1'b0; step(10); bus.enable = 1'b0; step(4);
    bus.enable = 1'b1; step(4); bus.rx_in[0] = 1'b1;
    settle();

    // 7: second falling edge 5 cycles into the stretch retriggers it
    start(7);
    ev(6, 5'b10001); ev(10, 5'b11001); ev(11, 5'b01001);
    ev(15, 5'b11001); ev(21, 5'b11000);
    bus.rx_in[0] = 1'b0; step(4); bus.rx_in[0] = 1'b1; step(1);
    bus.rx_in[1] = 1'b0; step(4); bus.rx_in[1] = 1'b1;
    settle();

    // 8: simultaneous falls on both channels form a single LED load
    start(8);
    ev(6, 5'b00001); ev(10, 5'b11001); ev(16, 5'b11000);
    bus.rx_in = 2'b00; step(4); bus.rx_in = 2'b11;
    settle();

    // 9: asynchronous reset in the middle of a ch1 break, line still low after
    start(9);
    ev(6, 5'b01001); ev(16, 5'b01000); ev(21, 5'b01100); ev(25, IDLE);
    bus.rx_in[1] = 1'b0; step(25);
    #1 nrst = 1'b0;
    #1 chk_now("async_reset", IDLE);
    step(3);
    base = cyc;
    ev(6, 5'b01001); ev(16, 5'b01000); ev(21, 5'b01100); ev(36, 5'b11000);
    nrst = 1'b1;
    step(30); bus.rx_in[1] = 1'b1;
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
